// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: run controller and trace monitor for RISC-V core bring-up.
// Holds the core in reset for RST_CYCLES after a start pulse. It then lets the core run,
// counting cycles and recording {PC, instruction, ALU result} into a ring buffer. A run ends
// on a halt instruction, a PC that stops changing, or a cycle-budget timeout.
//
// Handshake: start is a single-cycle pulse that is only acted on in IDLE or DONE;
// there is no ready/ack, a start seen in RESET or RUN is simply dropped.
module riscv_run_monitor #(
    parameter int              PC_W        = 9,
    parameter int              INS_W       = 32,
    parameter int              DATA_W      = 64,
    parameter int              RST_CYCLES  = 2,
    parameter int              MAX_CYCLES  = 100,
    parameter int              STALL_LIMIT = 4,
    parameter int              TRACE_DEPTH = 8,
    parameter logic [INS_W-1:0] HALT_INS   = 32'h00000073
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PC_W-1:0]                  PC_in,
    input  logic [INS_W-1:0]                 INS_in,
    input  logic [DATA_W-1:0]                ALU_in,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_rd_idx,
    output logic                             core_rst,
    output logic                             running,
    output logic                             done,
    output logic [1:0]                       status,
    output logic [31:0]                      cycle_cnt,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count,
    output logic [PC_W-1:0]                  trace_pc,
    output logic [INS_W-1:0]                 trace_ins,
    output logic [DATA_W-1:0]                trace_alu,
    output logic [1:0]                       dbg_state
);

    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SC_W  = $clog2(STALL_LIMIT + 1);

    localparam logic [RC_W-1:0]  RST_LAST    = RC_W'(RST_CYCLES - 1);
    localparam logic [SC_W-1:0]  STALL_LIM_V = SC_W'(STALL_LIMIT);
    localparam logic [31:0]      MAX_CYC_V   = 32'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] DEPTH_V     = CNT_W'(TRACE_DEPTH);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_STUCK   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [RC_W-1:0]   rst_cnt;
    logic [IDX_W-1:0]  wr_ptr;
    logic [SC_W-1:0]   stall_cnt;
    logic [SC_W-1:0]   stall_next;
    logic [PC_W-1:0]   pc_prev;
    logic [31:0]       cnt_inc;
    logic              end_hit;
    logic [1:0]        end_status;

    logic [PC_W-1:0]   buf_pc  [TRACE_DEPTH];
    logic [INS_W-1:0]  buf_ins [TRACE_DEPTH];
    logic [DATA_W-1:0] buf_alu [TRACE_DEPTH];

    logic [IDX_W-1:0]  oldest;
    logic [IDX_W-1:0]  rd_addr;
    logic              rd_valid;

    // The core is released only while running; DONE re-asserts reset to freeze it.
    assign core_rst  = (state != S_RUN);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and end-of-run detection on the cycle being sampled.
    always_comb begin
        state_next = state;
        end_hit    = 1'b0;
        end_status = ST_NONE;
        cnt_inc    = cycle_cnt + 32'd1;
        // cycle_cnt is zero exactly on the first RUN cycle; there is no previous PC yet.
        if ((cycle_cnt != 32'd0) && (PC_in == pc_prev)) begin
            stall_next = stall_cnt + SC_W'(1);
        end else begin
            stall_next = SC_W'(1);
        end
        if (INS_in == HALT_INS) begin
            end_hit    = 1'b1;
            end_status = ST_HALT;
        end else if (stall_next == STALL_LIM_V) begin
            end_hit    = 1'b1;
            end_status = ST_STUCK;
        end else if (cnt_inc == MAX_CYC_V) begin
            end_hit    = 1'b1;
            end_status = ST_TIMEOUT;
        end
        case (state)
            S_IDLE:  if (start) state_next = S_RESET;
            S_RESET: if (rst_cnt == RST_LAST) state_next = S_RUN;
            S_RUN:   if (end_hit) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RESET;
            default: state_next = S_IDLE;
        endcase
    end

    // Run counters, stall tracking, status and the registered state decodes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt     <= '0;
            cycle_cnt   <= '0;
            trace_count <= '0;
            wr_ptr      <= '0;
            stall_cnt   <= '0;
            pc_prev     <= '0;
            status      <= ST_NONE;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            running <= (state_next == S_RUN);
            done    <= (state_next == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rst_cnt     <= '0;
                        cycle_cnt   <= '0;
                        trace_count <= '0;
                        wr_ptr      <= '0;
                        stall_cnt   <= '0;
                        status      <= ST_NONE;
                    end
                end
                S_RESET: begin
                    rst_cnt <= rst_cnt + RC_W'(1);
                end
                S_RUN: begin
                    wr_ptr    <= wr_ptr + IDX_W'(1);
                    cycle_cnt <= cnt_inc;
                    pc_prev   <= PC_in;
                    stall_cnt <= stall_next;
                    if (trace_count != DEPTH_V) begin
                        trace_count <= trace_count + CNT_W'(1);
                    end
                    if (end_hit) begin
                        status <= end_status;
                    end
                end
                default: ;
            endcase
        end
    end

    // Trace ring buffer: one entry per RUN cycle, the oldest is overwritten once full.
    always_ff @(posedge clk) begin
        if (state == S_RUN) begin
            buf_pc[wr_ptr]  <= PC_in;
            buf_ins[wr_ptr] <= INS_in;
            buf_alu[wr_ptr] <= ALU_in;
        end
    end

    // Combinational trace read, index 0 is the oldest valid entry.
    always_comb begin
        oldest    = (trace_count == DEPTH_V) ? wr_ptr : '0;
        rd_addr   = oldest + trace_rd_idx;
        rd_valid  = ({1'b0, trace_rd_idx} < trace_count);
        trace_pc  = '0;
        trace_ins = '0;
        trace_alu = '0;
        if (rd_valid) begin
            trace_pc  = buf_pc[rd_addr];
            trace_ins = buf_ins[rd_addr];
            trace_alu = buf_alu[rd_addr];
        end
    end

endmodule
